// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the XNOR-feedback LFSR stream, one bit per valid cycle
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset, clears all state
//   din       : received sequence bit (generator word bit 0)
//   din_valid : din sampled only when high; all state held otherwise
//   err_clr   : synchronous clear of err_cnt, wins over a same-cycle increment
//   locked    : registered, high while in LOCKED
//   err_pulse : registered one-cycle pulse per mispredicted bit while LOCKED
//   err_cnt   : saturating count of mispredicted bits while LOCKED
module prbs_checker #(
  parameter int N           = 8,
  parameter int LOCK_CNT    = 16,
  parameter int LOSS_THRESH = 4,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  input  logic          din_valid,
  input  logic          err_clr,
  output logic          locked,
  output logic          err_pulse,
  output logic [CW-1:0] err_cnt
);
  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [N-1:0] TAP =
    N == 3 ? N'(6)   :
    N == 4 ? N'(12)  :
    N == 5 ? N'(20)  :
    N == 6 ? N'(48)  :
    N == 7 ? N'(96)  :
    N == 8 ? N'(184) :
    N == 9 ? N'(272) : N'(576);
  localparam logic [3:0] FILL_LAST  = 4'(N - 1);
  localparam logic [7:0] MATCH_LAST = 8'(LOCK_CNT - 1);
  localparam logic [3:0] MISS_LAST  = 4'(LOSS_THRESH - 1);
  logic [1:0]   state, state_n;
  logic [N-1:0] sh, sh_n;
  logic [3:0]   fill, fill_n;
  logic [7:0]   match, match_n;
  logic [3:0]   miss, miss_n;
  logic         p, wrong, err;
  assign p     = ~^(sh & TAP);
  assign wrong = din != p;
  assign err   = din_valid && state == LOCKED && wrong;
  always_comb begin
    state_n = state;
    sh_n    = sh;
    fill_n  = fill;
    match_n = match;
    miss_n  = miss;
    if (din_valid)
      case (state)
        SEARCH: begin
          sh_n   = {sh[N-2:0], din};
          fill_n = fill + 1'b1;
          if (fill == FILL_LAST) begin
            state_n = VERIFY;
            fill_n  = '0;
            match_n = '0;
          end
        end
        VERIFY: begin
          // all-ones is the lockup state, so it can never be trusted as a seed
          if (wrong || &sh) begin
            state_n = SEARCH;
            fill_n  = '0;
          end else begin
            sh_n    = {sh[N-2:0], din};
            match_n = match + 1'b1;
            if (match == MATCH_LAST) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end
        end
        LOCKED: begin
          // free-run on the prediction so a flipped bit cannot poison the shadow
          sh_n   = {sh[N-2:0], p};
          miss_n = wrong ? miss + 1'b1 : '0;
          if (wrong && miss == MISS_LAST) begin
            state_n = SEARCH;
            fill_n  = '0;
            miss_n  = '0;
          end
        end
        default: state_n = SEARCH;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= SEARCH;
      sh        <= '0;
      fill      <= '0;
      match     <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      fill      <= fill_n;
      match     <= match_n;
      miss      <= miss_n;
      locked    <= state_n == LOCKED;
      err_pulse <= err;
      if (err_clr) err_cnt <= '0;
      else if (err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed bench for prbs_checker against a model of the N=8 XNOR generator
module tb_prbs_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic        locked8, pulse8, locked4, pulse4;
  logic [15:0] cnt8;
  logic [3:0]  cnt4;
  logic [7:0]  g;
  int          total = 0;
  int          bad = 0;

  prbs_checker #(.N(8), .LOCK_CNT(16), .LOSS_THRESH(4), .CW(16)) u8 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .err_clr(err_clr),
    .locked(locked8), .err_pulse(pulse8), .err_cnt(cnt8));

  prbs_checker #(.N(8), .LOCK_CNT(16), .LOSS_THRESH(4), .CW(4)) u4 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .err_clr(err_clr),
    .locked(locked4), .err_pulse(pulse4), .err_cnt(cnt4));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic gen(output logic b);
    g = {g[6:0], ~(g[7] ^ g[5] ^ g[4] ^ g[3])};
    b = g[0];
  endtask

  task automatic drive(input logic d, input logic v, input logic c);
    din = d;
    din_valid = v;
    err_clr = c;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic good_bit();
    logic b;
    gen(b);
    drive(b, 1'b1, 1'b0);
  endtask

  task automatic bad_bit();
    logic b;
    gen(b);
    drive(~b, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    g = 8'h01;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++; if (locked8 !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked8); end
    total++; if (pulse8 !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b want=0", pulse8); end
    total++; if (cnt8 !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt8); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    g = 8'h01;
  endtask

  task automatic test_lock();
    logic seen;
    do_reset();
    seen = 1'b0;
    for (int i = 1; i <= 23; i++) begin
      good_bit();
      seen |= locked8;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL lock_early got=%b want=0", seen); end
    good_bit();
    total++; if (locked8 !== 1'b1) begin bad++; $display("FAIL lock_bit24 got=%b want=1", locked8); end
    total++; if (locked4 !== 1'b1) begin bad++; $display("FAIL lock_bit24_cw4 got=%b want=1", locked4); end
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      good_bit();
      seen |= pulse8 | ~locked8;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL lock_run_clean got=%b want=0", seen); end
    total++; if (cnt8 !== 16'd0) begin bad++; $display("FAIL lock_run_cnt got=%0d want=0", cnt8); end
  endtask

  task automatic test_single_error();
    logic seen;
    bad_bit();
    total++; if (pulse8 !== 1'b1) begin bad++; $display("FAIL single_pulse got=%b want=1", pulse8); end
    total++; if (cnt8 !== 16'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", cnt8); end
    total++; if (locked8 !== 1'b1) begin bad++; $display("FAIL single_locked got=%b want=1", locked8); end
    good_bit();
    total++; if (pulse8 !== 1'b0) begin bad++; $display("FAIL single_pulse_width got=%b want=0", pulse8); end
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      good_bit();
      seen |= pulse8;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL single_after got=%b want=0", seen); end
    total++; if (cnt8 !== 16'd1) begin bad++; $display("FAIL single_cnt_hold got=%0d want=1", cnt8); end
  endtask

  task automatic test_loss();
    logic seen;
    drive(1'b0, 1'b0, 1'b1);
    total++; if (cnt8 !== 16'd0) begin bad++; $display("FAIL loss_clear got=%0d want=0", cnt8); end
    repeat (3) bad_bit();
    total++; if (locked8 !== 1'b1) begin bad++; $display("FAIL loss_after3 got=%b want=1", locked8); end
    bad_bit();
    total++; if (locked8 !== 1'b0) begin bad++; $display("FAIL loss_after4 got=%b want=0", locked8); end
    total++; if (cnt8 !== 16'd4) begin bad++; $display("FAIL loss_cnt got=%0d want=4", cnt8); end
    total++; if (pulse8 !== 1'b1) begin bad++; $display("FAIL loss_pulse4 got=%b want=1", pulse8); end
    seen = 1'b0;
    for (int i = 1; i <= 23; i++) begin
      good_bit();
      seen |= locked8;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL relock_early got=%b want=0", seen); end
    good_bit();
    total++; if (locked8 !== 1'b1) begin bad++; $display("FAIL relock_bit24 got=%b want=1", locked8); end
    total++; if (cnt8 !== 16'd4) begin bad++; $display("FAIL relock_cnt got=%0d want=4", cnt8); end
  endtask

  task automatic test_saturation();
    logic b;
    drive(1'b0, 1'b0, 1'b1);
    repeat (20) begin
      bad_bit();
      good_bit();
      good_bit();
    end
    total++; if (cnt4 !== 4'd15) begin bad++; $display("FAIL sat_cw4 got=%0d want=15", cnt4); end
    total++; if (cnt8 !== 16'd20) begin bad++; $display("FAIL sat_cw16 got=%0d want=20", cnt8); end
    total++; if (locked4 !== 1'b1) begin bad++; $display("FAIL sat_locked got=%b want=1", locked4); end
    bad_bit();
    good_bit();
    total++; if (cnt4 !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d want=15", cnt4); end
    total++; if (cnt8 !== 16'd21) begin bad++; $display("FAIL sat_cw16_21 got=%0d want=21", cnt8); end
    gen(b);
    drive(~b, 1'b1, 1'b1);
    total++; if (cnt4 !== 4'd0) begin bad++; $display("FAIL clr_cw4 got=%0d want=0", cnt4); end
    total++; if (cnt8 !== 16'd0) begin bad++; $display("FAIL clr_cw16 got=%0d want=0", cnt8); end
    total++; if (pulse4 !== 1'b1) begin bad++; $display("FAIL clr_pulse got=%b want=1", pulse4); end
  endtask

  task automatic test_stall();
    logic [31:0] pat;
    logic        early, idle_bad, b;
    int          nv;
    do_reset();
    pat = 32'hB53C96E1;
    nv = 0;
    early = 1'b0;
    idle_bad = 1'b0;
    for (int cyc = 0; cyc < 400 && nv < 24; cyc++) begin
      if (pat[cyc % 32]) begin
        gen(b);
        drive(b, 1'b1, 1'b0);
        nv++;
        if (nv < 24) early |= locked8;
      end else begin
        drive(cyc[1], 1'b0, 1'b0);
        idle_bad |= locked8 | pulse8;
      end
    end
    total++; if (nv !== 24) begin bad++; $display("FAIL stall_valid_count got=%0d want=24", nv); end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL stall_early got=%b want=0", early); end
    total++; if (idle_bad !== 1'b0) begin bad++; $display("FAIL stall_idle got=%b want=0", idle_bad); end
    total++; if (locked8 !== 1'b1) begin bad++; $display("FAIL stall_lock got=%b want=1", locked8); end
    drive(1'b0, 1'b0, 1'b0);
    total++; if (locked8 !== 1'b1) begin bad++; $display("FAIL stall_hold got=%b want=1", locked8); end
  endtask

  task automatic test_lockup();
    logic seen;
    do_reset();
    seen = 1'b0;
    repeat (200) begin
      drive(1'b1, 1'b1, 1'b0);
      seen |= locked8;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL lockup_locked got=%b want=0", seen); end
  endtask

  task automatic test_reset_mid_lock();
    logic seen;
    do_reset();
    repeat (24) good_bit();
    bad_bit();
    good_bit();
    total++; if (locked8 !== 1'b1) begin bad++; $display("FAIL midrst_pre_locked got=%b want=1", locked8); end
    total++; if (cnt8 !== 16'd1) begin bad++; $display("FAIL midrst_pre_cnt got=%0d want=1", cnt8); end
    #2 rst = 1'b1;
    #1;
    total++; if (locked8 !== 1'b0) begin bad++; $display("FAIL midrst_locked got=%b want=0", locked8); end
    total++; if (cnt8 !== 16'd0) begin bad++; $display("FAIL midrst_cnt got=%0d want=0", cnt8); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 23; i++) begin
      good_bit();
      seen |= locked8;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_early got=%b want=0", seen); end
    good_bit();
    total++; if (locked8 !== 1'b1) begin bad++; $display("FAIL midrst_relock got=%b want=1", locked8); end
  endtask

  initial begin
    g = 8'h01;
    test_reset();
    test_lock();
    test_single_error();
    test_loss();
    test_saturation();
    test_stall();
    test_lockup();
    test_reset_mid_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
